anim_sprite_src: RTL and testbench
==================================

ANIM_SPRITE_SRC -- requirements
Module: anim_sprite_src

Interface
REQ-001 Parameter CD, default 12, pixel colour depth in bits.
REQ-002 Parameter H_SIZE, default 32, sprite width in pixels; power of 2.
REQ-003 Parameter V_SIZE, default 32, sprite height in pixels; power of 2.
REQ-004 Parameter NFRAME, default 4, number of animation frames; power of 2, at least 1.
REQ-005 Parameter KEY_COLOR, default 0, chroma-key (transparent) colour.
REQ-006 Derived localparam ADDR = log2(H_SIZE*V_SIZE*NFRAME).
REQ-007 clk  in  1  Single system clock; all logic is on its rising edge.
REQ-008 reset_n  in  1  Reset; synchronous and active-low.
REQ-009 x, y  in  11 each  Current scan pixel coordinate.
REQ-010 x0, y0  in  11 each  Sprite origin (top-left corner).
REQ-011 we  in  1  Sprite RAM write enable.
REQ-012 addr_w  in  ADDR  Sprite RAM write address, ordered {frame, row, col}.
REQ-013 pixel_in  in  CD  Sprite RAM write data.
REQ-014 frame_start  in  1  One-cycle pulse at the start of each video frame.
REQ-015 ctrl  in  4  {anim_en, scale2x, vflip, hflip}; shadowed and applied at frame_start.
REQ-016 frame_period  in  8  Number of video frames per animation step, minus 1.
REQ-017 sprite_rgb  out  CD  Pixel output, or KEY_COLOR where the sprite is absent.
REQ-018 sprite_hit  out  1  High when in region and the RAM pixel is not KEY_COLOR; aligned with sprite_rgb.
REQ-019 frame_idx  out  log2(NFRAME) (1 bit if NFRAME=1)  Animation frame currently displayed.

Function
REQ-020 Relative coordinates xr = x - x0 and yr = y - y0 are computed signed at 12 bits.
REQ-021 Region extents: W = H_SIZE and H = V_SIZE at 1x; W = 2*H_SIZE and H = 2*V_SIZE when the active scale2x bit is set.
REQ-022 in_region = 0 <= xr < W and 0 <= yr < H; negative or out-of-range values are outside the region.
REQ-023 Column index cx = xr >> scale; with hflip, cx' = H_SIZE-1-cx, otherwise cx' = cx.
REQ-024 Row index ry = yr >> scale; with vflip, ry' = V_SIZE-1-ry, otherwise ry' = ry.
REQ-025 Read address = {frame_idx, ry', cx'}.
REQ-026 The RAM is synchronous with 1-cycle read latency; the write port is independent.
REQ-027 A simultaneous read and write to the same address returns the old data.
REQ-028 Pipeline stage 1 registers the RAM read and in_region; stage 2 registers sprite_rgb and sprite_hit.
REQ-029 Total latency from x/y to output is 2 cycles; in_region and flip/scale are delayed to match.
REQ-030 Shadow control registers load ctrl only on a cycle where frame_start=1, so there is no mid-frame tearing.
REQ-031 Frame counter tick_cnt is 8 bits.
REQ-032 On frame_start with anim_en: if tick_cnt == frame_period, tick_cnt <= 0 and frame_idx <= frame_idx+1 mod NFRAME (wraps NFRAME-1 -> 0); otherwise tick_cnt <= tick_cnt+1.
REQ-033 frame_period=0 advances frame_idx on every frame_start.
REQ-034 The anim_en used in REQ-032 is the value being shadowed on that same frame_start, i.e. the new ctrl value.
REQ-035 With anim_en=0, tick_cnt and frame_idx hold their values.
REQ-036 A frame_period change takes effect at the next compare; if tick_cnt > frame_period, the counter continues to 255, wraps to 0, and then matches.
REQ-037 frame_idx changes only on frame_start, so frame_idx is constant within a frame.
REQ-038 Frame advance to displayed pixels is governed by the pipeline: pixels sampled up to 2 cycles after frame_start still use the old frame; frame_start is required during blanking.

Reset
REQ-039 While reset_n=0 at a clock edge: sprite_rgb <= KEY_COLOR, sprite_hit <= 0, frame_idx <= 0, tick_cnt <= 0, shadow ctrl <= 0, and pipeline valid bits <= 0.
REQ-040 RAM contents are not reset.
REQ-041 A reset asserted mid-frame or mid-animation aborts immediately; the first post-reset outputs are KEY_COLOR/0 until the pipeline refills (2 cycles).

Verification
REQ-042 Load a ramp (pixel = addr) for frame 0; x0=y0=100, ctrl=0; scan x=100..131, y=100 -> sprite_rgb = 0..31, each 2 cycles after its input; x=99 and x=132 -> KEY_COLOR, hit=0.
REQ-043 hflip=1 and vflip=1 applied via frame_start; at (x,y)=(100,100) -> RAM[{0,31,31}]; at (131,131) -> RAM[0].
REQ-044 scale2x=1; x=100..163 -> each RAM column repeated twice; x=164 -> KEY_COLOR; y=163 is in region, y=164 is out.
REQ-045 anim_en=1, frame_period=2; 12 frame_start pulses -> frame_idx sequence 0,0,1,1,1,2,2,2,3,3,3,0 (wrap); ctrl change between pulses has no effect until the next pulse.
REQ-046 Pixel equal to KEY_COLOR inside the region -> sprite_hit=0; x0=2000 with x=5 (negative xr) -> out of region.
REQ-047 Assert reset_n=0 for 1 cycle with frame_idx=2, tick_cnt=1 -> next cycle frame_idx=0, tick_cnt=0, sprite_rgb=KEY_COLOR, sprite_hit=0.

Source files
------------

// File: rtl/anim_sprite_src.sv
`default_nettype none
// ============================================================================
// Module   : anim_sprite_src
// Purpose  : Animated, chroma-keyed sprite source for a raster pipeline.
//            The sprite image lives in an internal dual-port RAM holding
//            NFRAME frames of H_SIZE x V_SIZE pixels. Each scan coordinate
//            (x, y) is mapped to a sprite pixel relative to the origin
//            (x0, y0), with optional 2x scaling and horizontal/vertical
//            flip. The animation frame advances every (frame_period + 1)
//            video frames while animation is enabled.
// Ports    : clk, reset_n       - clock, synchronous active-low reset
//            x, y               - current scan coordinate
//            x0, y0             - sprite top-left origin
//            we, addr_w,
//            pixel_in           - sprite RAM write port, addr = {frame,row,col}
//            frame_start        - one-cycle pulse at each video frame start
//            ctrl               - {anim_en, scale2x, vflip, hflip}
//            frame_period       - video frames per animation step, minus 1
//            sprite_rgb         - sprite pixel or KEY_COLOR (2-cycle latency)
//            sprite_hit         - opaque sprite pixel present
//            frame_idx          - animation frame being displayed
// Revision : 1.0 - initial release
// ============================================================================
module anim_sprite_src #(
    parameter int             CD        = 12,
    parameter int             H_SIZE    = 32,
    parameter int             V_SIZE    = 32,
    parameter int             NFRAME    = 4,
    parameter logic [CD-1:0]  KEY_COLOR = '0
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [10:0]                                  x,
    input  logic [10:0]                                  y,
    input  logic [10:0]                                  x0,
    input  logic [10:0]                                  y0,
    input  logic                                         we,
    input  logic [$clog2(H_SIZE*V_SIZE*NFRAME)-1:0]      addr_w,
    input  logic [CD-1:0]                                pixel_in,
    input  logic                                         frame_start,
    input  logic [3:0]                                   ctrl,
    input  logic [7:0]                                   frame_period,
    output logic [CD-1:0]                                sprite_rgb,
    output logic                                         sprite_hit,
    output logic [((NFRAME > 1) ? $clog2(NFRAME) : 1)-1:0] frame_idx
);

    localparam int ADDR = $clog2(H_SIZE*V_SIZE*NFRAME);
    localparam int c_HB = $clog2(H_SIZE);
    localparam int c_VB = $clog2(V_SIZE);
    localparam int c_FW = (NFRAME > 1) ? $clog2(NFRAME) : 1;

    // ------------------------------------------------------------------
    // Shadowed control and animation counter
    // ------------------------------------------------------------------
    // Only {scale2x, vflip, hflip} need a shadow: anim_en is consumed on
    // the very frame_start that loads it.
    logic [2:0]      r_ctrl;
    logic [7:0]      r_tick;
    logic [c_FW-1:0] r_frame_idx;
    logic [c_FW-1:0] w_frame_next;

    // NFRAME is a power of two, so the natural wrap of the adder is the
    // modulo; a single frame must stay at 0.
    assign w_frame_next = (NFRAME == 1) ? '0 : r_frame_idx + c_FW'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ctrl      <= '0;
            r_tick      <= '0;
            r_frame_idx <= '0;
        end else if (frame_start) begin
            r_ctrl <= ctrl[2:0];
            if (ctrl[3]) begin
                // Equality compare only: if frame_period drops below the
                // current count, the counter runs through 255 and wraps.
                if (r_tick == frame_period) begin
                    r_tick      <= '0;
                    r_frame_idx <= w_frame_next;
                end else begin
                    r_tick <= r_tick + 8'd1;
                end
            end
        end
    end

    assign frame_idx = r_frame_idx;

    // ------------------------------------------------------------------
    // Address generation (cycle 0)
    // ------------------------------------------------------------------
    logic [11:0]       w_xr;
    logic [11:0]       w_yr;
    logic [11:0]       w_w;
    logic [11:0]       w_h;
    logic              w_in_region;
    logic [11:0]       w_xs;
    logic [11:0]       w_ys;
    logic [c_HB-1:0]   w_cx;
    logic [c_VB-1:0]   w_ry;
    logic [ADDR-1:0]   w_rd_addr;
    logic              w_unused;

    // Zero-extended 12-bit subtraction: bit 11 is the sign of the offset.
    assign w_xr = {1'b0, x} - {1'b0, x0};
    assign w_yr = {1'b0, y} - {1'b0, y0};

    assign w_w = r_ctrl[2] ? 12'(2*H_SIZE) : 12'(H_SIZE);
    assign w_h = r_ctrl[2] ? 12'(2*V_SIZE) : 12'(V_SIZE);

    assign w_in_region = !w_xr[11] && (w_xr < w_w) &&
                         !w_yr[11] && (w_yr < w_h);

    assign w_xs = r_ctrl[2] ? {1'b0, w_xr[11:1]} : w_xr;
    assign w_ys = r_ctrl[2] ? {1'b0, w_yr[11:1]} : w_yr;

    // SIZE-1-idx on a power-of-two index is a bitwise inversion.
    assign w_cx = r_ctrl[0] ? ~w_xs[c_HB-1:0] : w_xs[c_HB-1:0];
    assign w_ry = r_ctrl[1] ? ~w_ys[c_VB-1:0] : w_ys[c_VB-1:0];

    // Upper bits of the shifted offsets only matter through w_in_region.
    assign w_unused = &{1'b0, w_xs[11:c_HB], w_ys[11:c_VB]};

    generate
        if (NFRAME > 1) begin : g_addr_multi
            assign w_rd_addr = {r_frame_idx, w_ry, w_cx};
        end else begin : g_addr_single
            assign w_rd_addr = {w_ry, w_cx};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sprite RAM: independent write port, registered read (stage 1).
    // Same-address read/write returns the pre-write contents.
    // ------------------------------------------------------------------
    logic [CD-1:0] r_mem [0:(1<<ADDR)-1];
    logic [CD-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr_w] <= pixel_in;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    // ------------------------------------------------------------------
    // Stage 1 valid and stage 2 output registers
    // ------------------------------------------------------------------
    logic          r_v1;
    logic [CD-1:0] r_rgb;
    logic          r_hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_v1  <= 1'b0;
            r_rgb <= KEY_COLOR;
            r_hit <= 1'b0;
        end else begin
            r_v1  <= w_in_region;
            r_rgb <= r_v1 ? r_rd_data : KEY_COLOR;
            r_hit <= r_v1 && (r_rd_data != KEY_COLOR);
        end
    end

    assign sprite_rgb = r_rgb;
    assign sprite_hit = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_anim_sprite_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_anim_sprite_src
// Purpose  : Self-checking bench for anim_sprite_src (default parameters).
//            A behavioural model (sprite memory array, shadow control,
//            animation tick/frame integers) predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_anim_sprite_src;

    localparam int            CD  = 12;
    localparam int            HS  = 32;
    localparam int            VS  = 32;
    localparam int            NF  = 4;
    localparam int            AW  = 12;
    localparam logic [CD-1:0] KEY = '0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [10:0]   x, y, x0, y0;
    logic          we;
    logic [AW-1:0] addr_w;
    logic [CD-1:0] pixel_in;
    logic          frame_start;
    logic [3:0]    ctrl;
    logic [7:0]    frame_period;
    logic [CD-1:0] sprite_rgb;
    logic          sprite_hit;
    logic [1:0]    frame_idx;

    always #5 clk = ~clk;

    anim_sprite_src #(
        .CD(CD), .H_SIZE(HS), .V_SIZE(VS), .NFRAME(NF), .KEY_COLOR(KEY)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .x(x), .y(y), .x0(x0), .y0(y0),
        .we(we), .addr_w(addr_w), .pixel_in(pixel_in),
        .frame_start(frame_start), .ctrl(ctrl), .frame_period(frame_period),
        .sprite_rgb(sprite_rgb), .sprite_hit(sprite_hit), .frame_idx(frame_idx)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [CD-1:0] m_mem [0:4095];
    int            m_tick  = 0;
    int            m_frame = 0;
    logic [3:0]    m_ctrl  = 4'd0;

    int q_x[$];
    int q_y[$];

    function automatic void model_pixel(input int px, input int py,
                                        output logic [CD-1:0] rgb,
                                        output logic hit, output int a);
        int xr, yr, s, cx, ry;
        xr  = px - int'(x0);
        yr  = py - int'(y0);
        s   = m_ctrl[2] ? 2 : 1;
        rgb = KEY;
        hit = 1'b0;
        a   = -1;
        if (xr >= 0 && xr < HS*s && yr >= 0 && yr < VS*s) begin
            cx = xr / s;
            ry = yr / s;
            if (m_ctrl[0]) cx = HS - 1 - cx;
            if (m_ctrl[1]) ry = VS - 1 - ry;
            a   = m_frame*HS*VS + ry*HS + cx;
            rgb = m_mem[a];
            hit = (rgb != KEY);
        end
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (cycles) @(negedge clk);
        reset_n = 1'b1;
        m_tick  = 0;
        m_frame = 0;
        m_ctrl  = 4'd0;
    endtask

    task automatic pulse(input logic [3:0] c, input logic [7:0] p);
        @(negedge clk);
        ctrl         = c;
        frame_period = p;
        frame_start  = 1'b1;
        m_ctrl = c;
        if (c[3]) begin
            if (m_tick == int'(p)) begin
                m_tick  = 0;
                m_frame = (m_frame + 1) % NF;
            end else begin
                m_tick = (m_tick + 1) % 256;
            end
        end
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic write_px(input int a, input logic [CD-1:0] d);
        @(negedge clk);
        we       = 1'b1;
        addr_w   = AW'(a);
        pixel_in = d;
        m_mem[a] = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    // Streams q_x/q_y one pixel per cycle; each result is expected exactly
    // two cycles after its coordinate was presented.
    task automatic run_scan(input string name, input bit do_writes);
        logic [CD-1:0] er[$];
        logic          eh[$];
        logic [CD-1:0] r, d;
        logic          h;
        int            a, n, wa;
        n = q_x.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                n_total++;
                if (sprite_rgb !== er[i-2] || sprite_hit !== eh[i-2])
                    $display("FAIL %s[%0d] (%0d,%0d): rgb=%h hit=%b expected rgb=%h hit=%b",
                             name, i-2, q_x[i-2], q_y[i-2], sprite_rgb, sprite_hit,
                             er[i-2], eh[i-2]);
                else
                    n_pass++;
            end
            if (i < n) begin
                x = 11'(q_x[i]);
                y = 11'(q_y[i]);
                model_pixel(q_x[i], q_y[i], r, h, a);
                er.push_back(r);
                eh.push_back(h);
                we = 1'b0;
                if (do_writes) begin
                    // Every fourth write collides with the address read now.
                    wa = (a >= 0 && (i % 4) == 0) ? a : int'($urandom_range(0, 4095));
                    d  = CD'($urandom);
                    we       = 1'b1;
                    addr_w   = AW'(wa);
                    pixel_in = d;
                    m_mem[wa] = d;
                end
            end else begin
                we = 1'b0;
            end
        end
        we = 1'b0;
        q_x.delete();
        q_y.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (sprite_rgb !== KEY) $display("FAIL reset_rgb: got %h want %h", sprite_rgb, KEY);
        else n_pass++;
        n_total++;
        if (sprite_hit !== 1'b0) $display("FAIL reset_hit: got %b want 0", sprite_hit);
        else n_pass++;
        n_total++;
        if (frame_idx !== 2'd0) $display("FAIL reset_frame_idx: got %0d want 0", frame_idx);
        else n_pass++;
        reset_n = 1'b1;
        m_tick = 0; m_frame = 0; m_ctrl = 4'd0;
    endtask

    task automatic test_ramp();
        logic [CD-1:0] d;
        for (int a = 0; a < 4096; a++) begin
            @(negedge clk);
            d = (a < 1024) ? CD'(a) : CD'($urandom);
            we = 1'b1; addr_w = AW'(a); pixel_in = d;
            m_mem[a] = d;
        end
        @(negedge clk);
        we = 1'b0;
        x0 = 11'd100; y0 = 11'd100;
        pulse(4'b0000, 8'd0);
        for (int i = 99; i <= 132; i++) begin q_x.push_back(i); q_y.push_back(100); end
        q_x.push_back(110); q_y.push_back(99);
        q_x.push_back(110); q_y.push_back(131);
        q_x.push_back(110); q_y.push_back(132);
        run_scan("ramp", 1'b0);
    endtask

    task automatic test_flip();
        pulse(4'b0011, 8'd0);
        q_x.push_back(100); q_y.push_back(100);
        q_x.push_back(131); q_y.push_back(131);
        q_x.push_back(131); q_y.push_back(100);
        q_x.push_back(100); q_y.push_back(131);
        for (int i = 0; i < 40; i++) begin
            q_x.push_back(int'($urandom_range(95, 136)));
            q_y.push_back(int'($urandom_range(95, 136)));
        end
        run_scan("flip", 1'b0);
        pulse(4'b0001, 8'd0);
        for (int i = 100; i < 132; i += 7) begin q_x.push_back(i); q_y.push_back(105); end
        pulse(4'b0010, 8'd0);
        run_scan("hflip_then_vflip_shadow", 1'b0);
    endtask

    task automatic test_scale();
        pulse(4'b0100, 8'd0);
        for (int i = 99; i <= 165; i++) begin q_x.push_back(i); q_y.push_back(100); end
        for (int j = 162; j <= 165; j++) begin q_x.push_back(100); q_y.push_back(j); end
        for (int i = 0; i < 30; i++) begin
            q_x.push_back(int'($urandom_range(96, 168)));
            q_y.push_back(int'($urandom_range(96, 168)));
        end
        run_scan("scale2x", 1'b0);
        pulse(4'b0111, 8'd0);
        for (int i = 0; i < 30; i++) begin
            q_x.push_back(int'($urandom_range(96, 168)));
            q_y.push_back(int'($urandom_range(96, 168)));
        end
        run_scan("scale2x_flip", 1'b0);
    endtask

    task automatic test_anim();
        int seq[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            pulse(4'b1000, 8'd2);
            n_total++;
            if (frame_idx !== 2'(seq[i]))
                $display("FAIL anim_seq[%0d]: frame_idx=%0d want %0d", i, frame_idx, seq[i]);
            else n_pass++;
            if (i == 4) begin
                // Control change without frame_start must not be rendered.
                ctrl = 4'b0111;
                repeat (3) @(negedge clk);
                n_total++;
                if (frame_idx !== 2'(seq[i]))
                    $display("FAIL anim_no_pulse: frame_idx=%0d want %0d", frame_idx, seq[i]);
                else n_pass++;
                q_x.push_back(101); q_y.push_back(103);
                q_x.push_back(130); q_y.push_back(120);
                run_scan("ctrl_midframe", 1'b0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            pulse(4'b0000, 8'd0);
            n_total++;
            if (frame_idx !== 2'(m_frame))
                $display("FAIL anim_hold[%0d]: frame_idx=%0d want %0d", i, frame_idx, m_frame);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) pulse(4'b1000, 8'd5);
        for (int i = 0; i < 260; i++) begin
            pulse(4'b1000, 8'd1);
            n_total++;
            if (frame_idx !== 2'(m_frame))
                $display("FAIL anim_period_drop[%0d]: frame_idx=%0d want %0d", i, frame_idx, m_frame);
            else n_pass++;
        end
        while (m_frame != 2) pulse(4'b1000, 8'd0);
        for (int i = 0; i < 30; i++) begin
            q_x.push_back(int'($urandom_range(98, 134)));
            q_y.push_back(int'($urandom_range(98, 134)));
        end
        run_scan("frame2_scan", 1'b0);
    endtask

    task automatic test_key_neg();
        pulse(4'b0000, 8'd0);
        write_px(m_frame*1024 + 5*32 + 7, KEY);
        write_px(m_frame*1024 + 5*32 + 8, 12'h5A5);
        q_x.push_back(107); q_y.push_back(105);
        q_x.push_back(108); q_y.push_back(105);
        run_scan("key_pixel", 1'b0);
        @(negedge clk);
        x = 11'd107; y = 11'd105;
        repeat (2) @(negedge clk);
        n_total++;
        if (sprite_hit !== 1'b0) $display("FAIL key_hit: got %b want 0", sprite_hit);
        else n_pass++;
        x0 = 11'd2000;
        q_x.push_back(5);    q_y.push_back(105);
        q_x.push_back(2010); q_y.push_back(105);
        q_x.push_back(0);    q_y.push_back(100);
        run_scan("neg_xr", 1'b0);
        x0 = 11'd100;
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic [7:0] p;
        for (int b = 0; b < 6; b++) begin
            c = 4'($urandom);
            p = 8'($urandom_range(0, 3));
            pulse(c, p);
            x0 = 11'($urandom_range(8, 1900));
            y0 = 11'($urandom_range(8, 1900));
            for (int i = 0; i < 50; i++) begin
                q_x.push_back(int'(x0) + int'($urandom_range(0, 72)) - 6);
                q_y.push_back(int'(y0) + int'($urandom_range(0, 72)) - 6);
            end
            run_scan("random", 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        logic [CD-1:0] r;
        logic          h;
        int            a;
        do_reset(1);
        x0 = 11'd100; y0 = 11'd100;
        for (int i = 0; i < 7; i++) pulse(4'b1000, 8'd2);
        n_total++;
        if (frame_idx !== 2'd2) $display("FAIL pre_reset_frame: frame_idx=%0d want 2", frame_idx);
        else n_pass++;
        write_px(2*1024 + 10*32 + 10, 12'hABC);
        @(negedge clk);
        x = 11'd110; y = 11'd110;
        repeat (2) @(negedge clk);
        n_total++;
        if (sprite_rgb !== 12'hABC || sprite_hit !== 1'b1)
            $display("FAIL pre_reset_pixel: rgb=%h hit=%b want ABC 1", sprite_rgb, sprite_hit);
        else n_pass++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_tick = 0; m_frame = 0; m_ctrl = 4'd0;
        n_total++;
        if (frame_idx !== 2'd0 || sprite_rgb !== KEY || sprite_hit !== 1'b0)
            $display("FAIL mid_reset: frame_idx=%0d rgb=%h hit=%b want 0 %h 0",
                     frame_idx, sprite_rgb, sprite_hit, KEY);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (sprite_rgb !== KEY || sprite_hit !== 1'b0)
            $display("FAIL refill: rgb=%h hit=%b want %h 0", sprite_rgb, sprite_hit, KEY);
        else n_pass++;
        @(negedge clk);
        model_pixel(110, 110, r, h, a);
        n_total++;
        if (sprite_rgb !== r || sprite_hit !== h)
            $display("FAIL post_reset_pixel: rgb=%h hit=%b want %h %b", sprite_rgb, sprite_hit, r, h);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            pulse(4'b1000, 8'd2);
            n_total++;
            if (frame_idx !== 2'(m_frame))
                $display("FAIL post_reset_tick[%0d]: frame_idx=%0d want %0d", i, frame_idx, m_frame);
            else n_pass++;
        end
    endtask

    initial begin
        reset_n = 1'b0; x = '0; y = '0; x0 = '0; y0 = '0;
        we = 1'b0; addr_w = '0; pixel_in = '0;
        frame_start = 1'b0; ctrl = '0; frame_period = '0;
        test_reset();
        test_ramp();
        test_flip();
        test_scale();
        test_anim();
        test_key_neg();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
